mult_v2: RTL and testbench

MULT_V2 -- requirements
Module: mult_v2

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_v2_lane.sv | 53 +++++
 rtl/mult_v2.sv | 147 ++++++++++++++
 tb/tb_mult_v2.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths, sync bundle and sum-width helper for the mult_v2 pixel multiplier.
package mult_pkg;
  localparam int DEF_COE_WIDTH   = 16;
  localparam int DEF_COE_FRAC    = 10;
  localparam int DEF_COE_COUNT   = 3;
  localparam int DEF_PIXEL_WIDTH = 12;
  // wide enough for a per-pixel saturated lane count with up to 8 channels
  localparam int SATN_W          = 4;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  function automatic int sum_width(input int pw, input int cw, input int cnt);
    return pw + cw + $clog2(cnt);
  endfunction
endpackage

// File: rtl/mult_v2_lane.sv
// One channel: register inputs, multiply, round half up, saturate.
// The product is exported so the top can build the weighted sum.
module mult_v2_lane
  import mult_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int COE_WIDTH   = DEF_COE_WIDTH,
  parameter int COE_FRAC    = DEF_COE_FRAC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIXEL_WIDTH-1:0]           di_i,
  input  logic [COE_WIDTH-1:0]             coe_i,
  output logic [PIXEL_WIDTH+COE_WIDTH-1:0] prod_o,
  output logic [PIXEL_WIDTH-1:0]           res_o,
  output logic                             sat_o
);
  localparam int PRW = PIXEL_WIDTH + COE_WIDTH;
  localparam int RW  = PRW + 1 - COE_FRAC;
  localparam logic [PRW:0] HALF = {{PRW{1'b0}}, 1'b1} << (COE_FRAC - 1);

  logic [PIXEL_WIDTH-1:0] di_q, di_d;
  logic [COE_WIDTH-1:0]   coe_q, coe_d;
  logic [PRW-1:0]         prod_q, prod_d;
  logic [RW-1:0]          rnd_q, rnd_d;
  logic [PRW:0]           rnd_full;

  always_comb begin
    di_d     = di_i;
    coe_d    = coe_i;
    prod_d   = PRW'(di_q) * PRW'(coe_q);
    rnd_full = {1'b0, prod_q} + HALF;
    rnd_d    = rnd_full[PRW:COE_FRAC];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      di_q   <= '0;
      coe_q  <= '0;
      prod_q <= '0;
      rnd_q  <= '0;
    end else begin
      di_q   <= di_d;
      coe_q  <= coe_d;
      prod_q <= prod_d;
      rnd_q  <= rnd_d;
    end
  end

  assign prod_o = prod_q;
  assign sat_o  = |rnd_q[RW-1:PIXEL_WIDTH];
  assign res_o  = sat_o ? {PIXEL_WIDTH{1'b1}} : rnd_q[PIXEL_WIDTH-1:0];
endmodule

// File: rtl/mult_v2.sv
// Per-channel scale / weighted-sum pixel multiplier, fixed 4-clock latency,
// frame-synchronous coefficient update and per-frame saturation count.
module mult_v2
  import mult_pkg::*;
#(
  parameter int COE_WIDTH   = DEF_COE_WIDTH,
  parameter int COE_FRAC    = DEF_COE_FRAC,
  parameter int COE_COUNT   = DEF_COE_COUNT,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [COE_COUNT*COE_WIDTH-1:0]   coe_i,
  input  logic                             mode_i,
  input  logic [COE_COUNT*PIXEL_WIDTH-1:0] di_i,
  input  logic                             de_i,
  input  logic                             hs_i,
  input  logic                             vs_i,
  output logic [COE_COUNT*PIXEL_WIDTH-1:0] do_o,
  output logic                             de_o,
  output logic                             hs_o,
  output logic                             vs_o,
  output logic [15:0]                      sat_cnt_o
);
  localparam int PRW = PIXEL_WIDTH + COE_WIDTH;
  localparam int SW  = sum_width(PIXEL_WIDTH, COE_WIDTH, COE_COUNT);
  localparam int SRW = SW + 1 - COE_FRAC;
  localparam logic [SW:0] HALF = {{SW{1'b0}}, 1'b1} << (COE_FRAC - 1);
  localparam logic [COE_WIDTH-1:0] ONE = {{(COE_WIDTH-1){1'b0}}, 1'b1} << COE_FRAC;

  logic [COE_COUNT*COE_WIDTH-1:0]   coe_act_q, coe_act_d;
  logic                             mode_act_q, mode_act_d;
  logic                             vs_prev_q, vs_prev_d;
  logic                             armed_q, armed_d;
  logic [2:0]                       mode_q, mode_d;
  sync_t [3:0]                      sync_q, sync_d;
  logic [SRW-1:0]                   sum_rnd_q, sum_rnd_d;
  logic [COE_COUNT*PIXEL_WIDTH-1:0] do_q, do_d;
  logic [SATN_W-1:0]                sat_n_q, sat_n_d;
  logic [15:0]                      cnt_q, cnt_d;
  logic [15:0]                      sat_cnt_q, sat_cnt_d;

  logic [COE_COUNT-1:0][PRW-1:0]         prod;
  logic [COE_COUNT-1:0][PIXEL_WIDTH-1:0] res;
  logic [COE_COUNT-1:0]                  lane_sat;
  logic                                  frame_start, vs_fall, sum_sat;
  logic [SW:0]                           sum;
  logic [16:0]                           acc;
  logic [15:0]                           acc_sat;

  // coe_act_q enters each lane's stage 1 with the pixel, so a capture only
  // affects pixels sampled after the frame-start cycle.
  for (genvar g = 0; g < COE_COUNT; g++) begin : g_lane
    mult_v2_lane #(
      .PIXEL_WIDTH(PIXEL_WIDTH),
      .COE_WIDTH  (COE_WIDTH),
      .COE_FRAC   (COE_FRAC)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .di_i  (di_i[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .coe_i (coe_act_q[g*COE_WIDTH +: COE_WIDTH]),
      .prod_o(prod[g]),
      .res_o (res[g]),
      .sat_o (lane_sat[g])
    );
  end

  // armed_q blocks a frame start until vs_i has been seen low since reset
  assign frame_start = vs_i & ~vs_prev_q & armed_q;
  assign vs_fall     = sync_q[3].vs & ~sync_q[2].vs;

  always_comb begin
    coe_act_d  = coe_act_q;
    mode_act_d = mode_act_q;
    if (frame_start) begin
      coe_act_d  = coe_i;
      mode_act_d = mode_i;
    end
    vs_prev_d = vs_i;
    armed_d   = armed_q | ~vs_i;
    mode_d    = {mode_q[1:0], mode_act_q};
    sync_d    = {sync_q[2:0], de_i, hs_i, vs_i};

    sum = '0;
    for (int n = 0; n < COE_COUNT; n++) sum = sum + (SW+1)'(prod[n]);
    sum       = sum + HALF;
    sum_rnd_d = sum[SW:COE_FRAC];

    do_d    = '0;
    sat_n_d = '0;
    sum_sat = |sum_rnd_q[SRW-1:PIXEL_WIDTH];
    if (mode_q[2]) begin
      do_d[PIXEL_WIDTH-1:0] = sum_sat ? {PIXEL_WIDTH{1'b1}} : sum_rnd_q[PIXEL_WIDTH-1:0];
      sat_n_d               = SATN_W'(sum_sat);
    end else begin
      for (int n = 0; n < COE_COUNT; n++) begin
        do_d[n*PIXEL_WIDTH +: PIXEL_WIDTH] = res[n];
        sat_n_d = sat_n_d + SATN_W'(lane_sat[n]);
      end
    end

    // the output in flight when vs_o drops belongs to the finished frame
    acc       = {1'b0, cnt_q} + 17'(sync_q[3].de ? sat_n_q : '0);
    acc_sat   = acc[16] ? 16'hFFFF : acc[15:0];
    cnt_d     = acc_sat;
    sat_cnt_d = sat_cnt_q;
    if (vs_fall) begin
      sat_cnt_d = acc_sat;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coe_act_q  <= {COE_COUNT{ONE}};
      mode_act_q <= 1'b0;
      vs_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      mode_q     <= '0;
      sync_q     <= '0;
      sum_rnd_q  <= '0;
      do_q       <= '0;
      sat_n_q    <= '0;
      cnt_q      <= '0;
      sat_cnt_q  <= '0;
    end else begin
      coe_act_q  <= coe_act_d;
      mode_act_q <= mode_act_d;
      vs_prev_q  <= vs_prev_d;
      armed_q    <= armed_d;
      mode_q     <= mode_d;
      sync_q     <= sync_d;
      sum_rnd_q  <= sum_rnd_d;
      do_q       <= do_d;
      sat_n_q    <= sat_n_d;
      cnt_q      <= cnt_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign do_o      = do_q;
  assign de_o      = sync_q[3].de;
  assign hs_o      = sync_q[3].hs;
  assign vs_o      = sync_q[3].vs;
  assign sat_cnt_o = sat_cnt_q;
endmodule

// File: tb/tb_mult_v2.sv
// Bench for mult_v2: spec vectors, frame-level sequences and random frames
// checked every cycle against an arithmetic model of the pixel pipeline.
module tb_mult_v2;
  localparam int CW = 16;
  localparam int CF = 10;
  localparam int CC = 3;
  localparam int PW = 12;
  localparam logic [CC*CW-1:0] ONE3 = {CC{16'h0400}};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CC*CW-1:0]  coe_i = '0;
  logic              mode_i = 1'b0;
  logic [CC*PW-1:0]  di_i = '0;
  logic              de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [CC*PW-1:0]  do_o;
  logic              de_o, hs_o, vs_o;
  logic [15:0]       sat_cnt_o;

  mult_v2 #(.COE_WIDTH(CW), .COE_FRAC(CF), .COE_COUNT(CC), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .coe_i(coe_i), .mode_i(mode_i), .di_i(di_i),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .do_o(do_o), .de_o(de_o),
    .hs_o(hs_o), .vs_o(vs_o), .sat_cnt_o(sat_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CC*PW-1:0] do_v;
    logic             de, hs, vs;
    int               nsat;
  } exp_t;

  typedef struct {
    string            name;
    logic [CC*CW-1:0] coe;
    logic             mode;
    logic [CC*PW-1:0] di;
    logic [CC*PW-1:0] exp_do;
  } vec_t;

  int               errors = 0;
  int               checks = 0;
  exp_t             hist[$];
  logic [CC*CW-1:0] act_coe = ONE3;
  logic             act_mode = 1'b0;
  logic             m_prev = 1'b0, m_armed = 1'b0;
  logic             prev_exp_vs = 1'b0;
  int               frame_cnt = 0, exp_satcnt = 0;
  logic [CC*PW-1:0] last_do;
  vec_t             vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // plain arithmetic: products, round half up, clamp
  function automatic exp_t model_out(input logic [CC*PW-1:0] di, input logic [CC*CW-1:0] coe,
                                     input logic mode, input logic d, input logic h, input logic v);
    exp_t   e;
    longint raw, s;
    e.do_v = '0; e.nsat = 0; e.de = d; e.hs = h; e.vs = v;
    s = 0;
    for (int n = 0; n < CC; n++) begin
      raw = longint'(di[n*PW +: PW]) * longint'(coe[n*CW +: CW]);
      s   = s + raw;
      raw = (raw + 512) >>> CF;
      if (!mode) begin
        if (raw > 4095) begin raw = 4095; e.nsat++; end
        e.do_v[n*PW +: PW] = raw[PW-1:0];
      end
    end
    if (mode) begin
      raw = (s + 512) >>> CF;
      if (raw > 4095) begin raw = 4095; e.nsat = 1; end
      e.do_v[PW-1:0] = raw[PW-1:0];
    end
    return e;
  endfunction

  function automatic logic [CC*PW-1:0] rdi();
    return {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
  endfunction

  function automatic logic [CC*CW-1:0] rcoe();
    logic [CC*CW-1:0] c;
    for (int n = 0; n < CC; n++)
      c[n*CW +: CW] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFF))
                                                   : 16'($urandom_range(0, 16'h0900));
    return c;
  endfunction

  function automatic logic rmode();
    return 1'($urandom_range(0, 1));
  endfunction

  // one clock: check what the DUT shows now, then drive the next inputs
  task automatic cyc(input logic r, input logic v, input logic h, input logic d,
                     input logic [CC*PW-1:0] di_v, input logic [CC*CW-1:0] coe_v, input logic mode_v);
    exp_t e, z;
    @(negedge clk);
    e = hist.pop_front();
    if (prev_exp_vs && !e.vs) begin exp_satcnt = frame_cnt; frame_cnt = 0; end
    if (e.de) frame_cnt = (frame_cnt + e.nsat > 65535) ? 65535 : frame_cnt + e.nsat;
    prev_exp_vs = e.vs;
    check("do", do_o, e.do_v);
    check("sync_satcnt", {de_o, hs_o, vs_o, sat_cnt_o}, {e.de, e.hs, e.vs, 16'(exp_satcnt)});
    last_do = do_o;
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      check("rst_async", {do_o, de_o, hs_o, vs_o, sat_cnt_o}, '0);
    end else rst = r;
    vs_i = v; hs_i = h; de_i = d; di_i = di_v; coe_i = coe_v; mode_i = mode_v;
    if (r) begin
      act_coe = ONE3; act_mode = 1'b0; m_prev = 1'b0; m_armed = 1'b0;
      frame_cnt = 0; exp_satcnt = 0; prev_exp_vs = 1'b0;
      z.do_v = '0; z.de = 0; z.hs = 0; z.vs = 0; z.nsat = 0;
      hist.delete();
      repeat (4) hist.push_back(z);
    end else begin
      hist.push_back(model_out(di_v, act_coe, act_mode, d, h, v));
      if (v && !m_prev && m_armed) begin act_coe = coe_v; act_mode = mode_v; end
      m_prev = v;
      if (!v) m_armed = 1'b1;
    end
  endtask

  initial begin
    exp_t z;
    z.do_v = '0; z.de = 0; z.hs = 0; z.vs = 0; z.nsat = 0;
    repeat (4) hist.push_back(z);

    vecs[0] = '{"unity",      {3{16'h0400}}, 1'b0, {3{12'd4090}}, {3{12'd4090}}};
    vecs[1] = '{"lane2_sat",  {16'h0800, 16'h0400, 16'h0400}, 1'b0, {3{12'd4090}},
                {12'd4095, 12'd4090, 12'd4090}};
    vecs[2] = '{"rnd_half",   {3{16'h0200}}, 1'b0, {3{12'd3}}, {3{12'd2}}};
    vecs[3] = '{"rnd_even",   {3{16'h0200}}, 1'b0, {3{12'd2}}, {3{12'd1}}};
    vecs[4] = '{"rnd_0x155",  {3{16'h0155}}, 1'b0, {3{12'd3}}, {3{12'd1}}};
    vecs[5] = '{"wsum",       {3{16'h0400}}, 1'b1, {3{12'd1000}}, {12'd0, 12'd0, 12'd3000}};
    vecs[6] = '{"wsum_sat",   {3{16'h0400}}, 1'b1, {3{12'd2000}}, {12'd0, 12'd0, 12'd4095}};
    vecs[7] = '{"zero_maxcoe", {16'h0000, 16'hFFFF, 16'h0400}, 1'b0, {12'd4095, 12'd1, 12'd0},
                {12'd0, 12'd64, 12'd0}};

    repeat (3) cyc(1, 0, 0, 0, '0, '0, 0);
    repeat (3) cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());
      cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());
      cyc(0, 1, 0, 0, rdi(), vecs[i].coe, vecs[i].mode);
      cyc(0, 1, 1, 1, vecs[i].di, rcoe(), rmode());
      repeat (4) cyc(0, 1, 1, 0, rdi(), rcoe(), rmode());
      check(vecs[i].name, last_do, vecs[i].exp_do);
      cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());
    end

    // 24x24 frame, lane 2 doubled into saturation on every pixel
    repeat (3) cyc(0, 0, 0, 0, rdi(), '0, 0);
    cyc(0, 1, 0, 0, rdi(), {16'h0800, 16'h0400, 16'h0400}, 1'b0);
    for (int l = 0; l < 24; l++) begin
      for (int p = 0; p < 24; p++) cyc(0, 1, 1, 1, {3{12'(4090 - p)}}, rcoe(), rmode());
      repeat (6) cyc(0, 1, 0, 0, rdi(), rcoe(), rmode());
    end
    repeat (6) cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());
    check("frame_sat_576", sat_cnt_o, 64'd576);

    // coefficient/mode changes mid-frame wait for the next frame start
    cyc(0, 1, 0, 0, '0, ONE3, 1'b0);
    repeat (10) cyc(0, 1, 1, 1, {3{12'd100}}, {3{16'h0800}}, 1'b1);
    repeat (4) cyc(0, 1, 0, 0, rdi(), {3{16'h0800}}, 1'b1);
    check("midframe_hold", last_do, {3{12'd100}});
    repeat (3) cyc(0, 0, 0, 0, rdi(), {3{16'h0800}}, 1'b1);
    cyc(0, 1, 0, 0, rdi(), {3{16'h0800}}, 1'b1);
    cyc(0, 1, 1, 1, {3{12'd100}}, rcoe(), rmode());
    repeat (4) cyc(0, 1, 0, 0, rdi(), rcoe(), rmode());
    check("next_frame_apply", last_do, {12'd0, 12'd0, 12'd600});
    repeat (3) cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());

    // reset mid-line, then a partial frame that must run at unity gain
    cyc(0, 1, 0, 0, rdi(), {3{16'h0200}}, 1'b0);
    repeat (6) cyc(0, 1, 1, 1, {3{12'd1000}}, rcoe(), rmode());
    cyc(1, 1, 1, 1, {3{12'd1000}}, rcoe(), rmode());
    cyc(1, 1, 1, 1, {3{12'd1000}}, rcoe(), rmode());
    repeat (5) cyc(0, 1, 1, 1, {3{12'd777}}, {3{16'h0800}}, 1'b1);
    repeat (4) cyc(0, 1, 0, 0, rdi(), {3{16'h0800}}, 1'b1);
    check("post_reset_unity", last_do, {3{12'd777}});
    repeat (3) cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());

    // random frames with random coefficient/mode churn on every cycle
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(2, 5)) cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());
      cyc(0, 1, 0, 0, rdi(), rcoe(), rmode());
      for (int l = 0; l < 6; l++) begin
        for (int p = 0; p < 16; p++)
          cyc(0, 1, 1, 1'($urandom_range(0, 3) != 0), rdi(), rcoe(), rmode());
        repeat (4) cyc(0, 1, 0, 0, rdi(), rcoe(), rmode());
      end
    end
    repeat (6) cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());

    // counter must stick at 0xFFFF instead of wrapping
    cyc(0, 1, 0, 0, rdi(), {3{16'hFFFF}}, 1'b0);
    repeat (22000) cyc(0, 1, 1, 1, {3{12'hFFF}}, rcoe(), rmode());
    repeat (6) cyc(0, 0, 0, 0, rdi(), rcoe(), rmode());
    check("sat_cnt_hold", sat_cnt_o, 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
